regm_mp: RTL and testbench

REGM_MP -- requirements
Module: regm_mp

---
 rtl/regm_mp_pkg.sv | 14 +
 rtl/regm_mp_sb.sv | 67 ++++++
 rtl/regm_mp.sv | 123 ++++++++++++
 tb/tb_regm_mp.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regm_mp_pkg.sv
// Shared types and default sizing for the multi-port register file (regm_mp).
package regm_mp_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NRD    = 2;
  localparam int DEF_NWR    = 2;

endpackage

// File: rtl/regm_mp_sb.sv
// Pending-claim scoreboard: one pend bit per entry. A claim sets the bit
// and a write clears it; when both hit one entry in the same cycle, the claim wins.
module regm_mp_sb
  import regm_mp_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD,
  parameter int NWR    = DEF_NWR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic [NWR-1:0]        wr_act,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic                  claim_en,
  input  logic [ADDR_W-1:0]     claim_addr,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD-1:0]        rd_pend
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] pend_r;
  logic [DEPTH-1:0] wr_hit_s;
  logic [DEPTH-1:0] claim_hit_s;
  logic             claim_act_s;

  assign claim_act_s = run & claim_en & (claim_addr != '0);

  // Decode this cycle's write and claim targets into per-entry hit vectors.
  always_comb begin
    wr_hit_s    = '0;
    claim_hit_s = '0;
    for (int i = 0; i < NWR; i++) begin
      if (wr_act[i]) begin
        wr_hit_s[wr_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
      end else begin
        wr_hit_s = wr_hit_s;
      end
    end
    if (claim_act_s) begin
      claim_hit_s[claim_addr] = 1'b1;
    end else begin
      claim_hit_s = '0;
    end
  end

  // Pend state update: clear on write, then set on claim so the claim dominates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= '0;
    end else begin
      pend_r <= (pend_r & ~wr_hit_s) | claim_hit_s;
    end
  end

  // A same-cycle write hides the pend bit unless a same-cycle claim re-marks it.
  always_comb begin
    rd_pend = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_pend[k] = pend_r[rd_addr[k*ADDR_W +: ADDR_W]]
                 & ~(wr_hit_s[rd_addr[k*ADDR_W +: ADDR_W]]
                     & ~claim_hit_s[rd_addr[k*ADDR_W +: ADDR_W]]);
    end
  end

endmodule

// File: rtl/regm_mp.sv
// Multi-port register file with post-reset clear sweep and pending-claim flags.
// Optional macro REGM_MP_BYPASS_EN forwards same-cycle write data to reads.
module regm_mp
  import regm_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD,
  parameter int NWR    = DEF_NWR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_pend,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic                  claim_en,
  input  logic [ADDR_W-1:0]     claim_addr,
  output logic                  init_busy
);

  localparam int         DEPTH   = 2**ADDR_W;
  localparam logic [0:0] ST_INIT = INIT;
  localparam logic [0:0] ST_RUN  = RUN;

  logic [0:0]        state_r;
  logic [ADDR_W-1:0] sweep_cnt_r;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              run_s;
  logic [NWR-1:0]    wr_act_s;
  logic [ADDR_W-1:0] wr_addr_a [NWR];
  logic [DATA_W-1:0] wr_data_a [NWR];
  logic [ADDR_W-1:0] rd_addr_a [NRD];

  assign run_s     = rst_n & (state_r == ST_RUN);
  assign init_busy = (state_r == ST_INIT);

  for (genvar i = 0; i < NWR; i++) begin : g_wr
    assign wr_addr_a[i] = wr_addr[i*ADDR_W +: ADDR_W];
    assign wr_data_a[i] = wr_data[i*DATA_W +: DATA_W];
    assign wr_act_s[i]  = run_s & wr_en[i] & (wr_addr_a[i] != '0);
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    assign rd_addr_a[k] = rd_addr[k*ADDR_W +: ADDR_W];
  end

  // INIT -> RUN sequencer; the counter walks every entry exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_INIT;
      sweep_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_INIT: begin
          sweep_cnt_r <= sweep_cnt_r + ADDR_W'(1);
          state_r     <= (&sweep_cnt_r) ? ST_RUN : ST_INIT;
        end
        ST_RUN: begin
          sweep_cnt_r <= sweep_cnt_r;
          state_r     <= ST_RUN;
        end
        default: begin
          sweep_cnt_r <= '0;
          state_r     <= ST_INIT;
        end
      endcase
    end
  end

  // Storage has no reset so it maps to RAM; later ports overwrite earlier ones.
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      mem_r[sweep_cnt_r] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (wr_act_s[i]) begin
          mem_r[wr_addr_a[i]] <= wr_data_a[i];
        end
      end
    end
  end

  // Combinational read ports; address 0 and the INIT phase always return zero.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      if (run_s && (rd_addr_a[k] != '0)) begin
        rd_data[k*DATA_W +: DATA_W] = mem_r[rd_addr_a[k]];
`ifdef REGM_MP_BYPASS_EN
        for (int i = 0; i < NWR; i++) begin
          if (wr_act_s[i] && (wr_addr_a[i] == rd_addr_a[k])) begin
            rd_data[k*DATA_W +: DATA_W] = wr_data_a[i];
          end else begin
            rd_data[k*DATA_W +: DATA_W] = rd_data[k*DATA_W +: DATA_W];
          end
        end
`endif
      end else begin
        rd_data[k*DATA_W +: DATA_W] = '0;
      end
    end
  end

  regm_mp_sb #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD),
    .NWR    (NWR)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run_s),
    .wr_act     (wr_act_s),
    .wr_addr    (wr_addr),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .rd_addr    (rd_addr),
    .rd_pend    (rd_pend)
  );

endmodule

// File: tb/tb_regm_mp.sv
// Directed scoreboard bench for regm_mp (default parameters, either build of REGM_MP_BYPASS_EN).
module tb_regm_mp;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pend;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        claim_en;
  logic [4:0]  claim_addr;
  logic        init_busy;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_chk;
  int   n_fail;

  regm_mp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pend    (rd_pend),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .init_busy  (init_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en      = 2'b00;
    wr_addr    = 10'd0;
    wr_data    = 64'd0;
    claim_en   = 1'b0;
    claim_addr = 5'd0;
  endtask

  // Release reset; write/claim attempts are held during the whole sweep.
  task automatic test_reset();
    int   cyc;
    logic bad;
    rst_n = 1'b1;
    idle();
    rd_addr = {5'd0, 5'd3};
    #1 rst_n = 1'b0;
    tick();
    tick();
    exp_q.push_back('{"rst_busy", 32'd1});
    exp_q.push_back('{"rst_pend", 32'd0});
    exp_q.push_back('{"rst_data", 32'd0});
    #1;
    e = exp_q.pop_front(); n_chk++;
    if ({31'd0, init_busy} !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, init_busy, e.exp); end
    e = exp_q.pop_front(); n_chk++;
    if ({30'd0, rd_pend} !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_pend, e.exp); end
    e = exp_q.pop_front(); n_chk++;
    if (rd_data[31:0] !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_data[31:0], e.exp); end

    tick();
    rst_n      = 1'b1;
    wr_en      = 2'b01;
    wr_addr    = {5'd0, 5'd5};
    wr_data    = {32'd0, 32'hCAFE_F00D};
    claim_en   = 1'b1;
    claim_addr = 5'd7;
    rd_addr    = {5'd5, 5'd7};
    exp_q.push_back('{"init_len", 32'd32});
    exp_q.push_back('{"init_quiet", 32'd0});
    cyc = 0;
    bad = 1'b0;
    while (cyc < 100) begin
      #1;
      if (init_busy !== 1'b1) break;
      if (rd_data !== 64'd0 || rd_pend !== 2'b00) bad = 1'b1;
      cyc++;
      tick();
    end
    e = exp_q.pop_front(); n_chk++;
    if (cyc !== int'(e.exp)) begin n_fail++; $display("FAIL %s: got %0d expected %0d", e.name, cyc, e.exp); end
    e = exp_q.pop_front(); n_chk++;
    if ({31'd0, bad} !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, bad, e.exp); end

    idle();
    exp_q.push_back('{"init_wr_ignored", 32'd0});
    exp_q.push_back('{"init_claim_ignored", 32'd0});
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (rd_data[63:32] !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_data[63:32], e.exp); end
    e = exp_q.pop_front(); n_chk++;
    if ({31'd0, rd_pend[0]} !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_pend[0], e.exp); end
  endtask

  // Two ports write addr 3 in one cycle; port 1 must win.
  task automatic test_write_priority();
    tick();
    wr_en   = 2'b11;
    wr_addr = {5'd3, 5'd3};
    wr_data = {32'h1234_5678, 32'hDEAD_BEEF};
    rd_addr = {5'd3, 5'd3};
`ifdef REGM_MP_BYPASS_EN
    exp_q.push_back('{"wr_prio_same_cycle", 32'h1234_5678});
`else
    exp_q.push_back('{"wr_prio_same_cycle", 32'h0000_0000});
`endif
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (rd_data[31:0] !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_data[31:0], e.exp); end
    tick();
    idle();
    exp_q.push_back('{"wr_prio_next_p0", 32'h1234_5678});
    exp_q.push_back('{"wr_prio_next_p1", 32'h1234_5678});
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (rd_data[31:0] !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_data[31:0], e.exp); end
    e = exp_q.pop_front(); n_chk++;
    if (rd_data[63:32] !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_data[63:32], e.exp); end
  endtask

  // Address 0 ignores writes and claims.
  task automatic test_addr_zero();
    tick();
    wr_en   = 2'b01;
    wr_addr = {5'd0, 5'd0};
    wr_data = {32'd0, 32'hFFFF_FFFF};
    rd_addr = {5'd0, 5'd0};
    exp_q.push_back('{"zero_same_cycle", 32'd0});
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (rd_data[31:0] !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_data[31:0], e.exp); end
    tick();
    idle();
    claim_en   = 1'b1;
    claim_addr = 5'd0;
    exp_q.push_back('{"zero_after_write", 32'd0});
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (rd_data[31:0] !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_data[31:0], e.exp); end
    tick();
    idle();
    exp_q.push_back('{"zero_claim_pend", 32'd0});
    #1;
    e = exp_q.pop_front(); n_chk++;
    if ({31'd0, rd_pend[0]} !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_pend[0], e.exp); end
  endtask

  // Claim addr 9, observe pend, then a write masks and clears it.
  task automatic test_claim();
    tick();
    claim_en   = 1'b1;
    claim_addr = 5'd9;
    rd_addr    = {5'd9, 5'd9};
    tick();
    idle();
    exp_q.push_back('{"claim_pend_set", 32'd1});
    #1;
    e = exp_q.pop_front(); n_chk++;
    if ({31'd0, rd_pend[0]} !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_pend[0], e.exp); end
    tick();
    wr_en   = 2'b10;
    wr_addr = {5'd9, 5'd0};
    wr_data = {32'hA5A5_0009, 32'd0};
    exp_q.push_back('{"claim_pend_masked", 32'd0});
    #1;
    e = exp_q.pop_front(); n_chk++;
    if ({31'd0, rd_pend[0]} !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_pend[0], e.exp); end
    tick();
    idle();
    exp_q.push_back('{"claim_pend_cleared", 32'd0});
    exp_q.push_back('{"claim_wr_data", 32'hA5A5_0009});
    #1;
    e = exp_q.pop_front(); n_chk++;
    if ({31'd0, rd_pend[1]} !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_pend[1], e.exp); end
    e = exp_q.pop_front(); n_chk++;
    if (rd_data[63:32] !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_data[63:32], e.exp); end
  endtask

  // Claim and write the same address in one cycle: claim wins, data lands.
  task automatic test_claim_write();
    tick();
    claim_en   = 1'b1;
    claim_addr = 5'd9;
    wr_en      = 2'b01;
    wr_addr    = {5'd0, 5'd9};
    wr_data    = {32'd0, 32'h0BAD_F00D};
    rd_addr    = {5'd9, 5'd9};
    tick();
    idle();
    exp_q.push_back('{"cw_pend", 32'd1});
    exp_q.push_back('{"cw_data", 32'h0BAD_F00D});
    #1;
    e = exp_q.pop_front(); n_chk++;
    if ({31'd0, rd_pend[0]} !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_pend[0], e.exp); end
    e = exp_q.pop_front(); n_chk++;
    if (rd_data[31:0] !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_data[31:0], e.exp); end
  endtask

  // Reset from RUN, then again at sweep cycle 10: full 32-cycle sweep restarts.
  task automatic test_reset_mid_sweep();
    int cyc;
    tick();
    rst_n   = 1'b0;
    rd_addr = {5'd9, 5'd3};
    exp_q.push_back('{"rrun_busy", 32'd1});
    exp_q.push_back('{"rrun_data", 32'd0});
    exp_q.push_back('{"rrun_pend", 32'd0});
    #1;
    e = exp_q.pop_front(); n_chk++;
    if ({31'd0, init_busy} !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, init_busy, e.exp); end
    e = exp_q.pop_front(); n_chk++;
    if (rd_data[31:0] !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_data[31:0], e.exp); end
    e = exp_q.pop_front(); n_chk++;
    if ({31'd0, rd_pend[1]} !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_pend[1], e.exp); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    exp_q.push_back('{"rmid_busy", 32'd1});
    #1;
    e = exp_q.pop_front(); n_chk++;
    if ({31'd0, init_busy} !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, init_busy, e.exp); end
    tick();
    rst_n = 1'b1;
    exp_q.push_back('{"rmid_len", 32'd32});
    cyc = 0;
    while (cyc < 100) begin
      #1;
      if (init_busy !== 1'b1) break;
      cyc++;
      tick();
    end
    e = exp_q.pop_front(); n_chk++;
    if (cyc !== int'(e.exp)) begin n_fail++; $display("FAIL %s: got %0d expected %0d", e.name, cyc, e.exp); end
    exp_q.push_back('{"rmid_data_cleared", 32'd0});
    exp_q.push_back('{"rmid_pend_cleared", 32'd0});
    #1;
    e = exp_q.pop_front(); n_chk++;
    if (rd_data[31:0] !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_data[31:0], e.exp); end
    e = exp_q.pop_front(); n_chk++;
    if ({31'd0, rd_pend[1]} !== e.exp) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rd_pend[1], e.exp); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b1;
    rd_addr = 10'd0;
    idle();
    test_reset();
    test_write_priority();
    test_addr_zero();
    test_claim();
    test_claim_write();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
